// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   In-order instruction fetch buffer between the PC / instruction memory and
//   decode. It also drives the PC advance/hold strobe (PCWrite_o) from its
//   own occupancy, and it drops everything it holds when the pipeline flushes.
//
//   Ports
//     clk_i          clock, rising edge
//     rst_i          synchronous reset, active low
//     pc_i/instr_i   fetch address and word, qualified by fetch_valid_i
//     PCWrite_o      1: fetch accepted, PC advances; 0: PC holds and refetches
//     flush_i        taken branch/jump; discard buffered and in-flight words
//     id_ready_i     decode consumes the head entry this cycle
//     id_valid_o     head entry valid
//     id_pc_o        head address (0 when empty)
//     id_pc_plus4_o  id_pc_o + 4 modulo 2^32 (4 when empty)
//     id_instr_o     head word (0 / nop when empty)
//     count_o        occupancy
//     flush_cnt_o    saturating count of flushes that discarded something
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              instr_i,
    input  logic                     fetch_valid_i,
    output logic                     PCWrite_o,
    input  logic                     flush_i,
    input  logic                     id_ready_i,
    output logic                     id_valid_o,
    output logic [31:0]              id_pc_o,
    output logic [31:0]              id_pc_plus4_o,
    output logic [31:0]              id_instr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         flush_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Storage has no reset; only the pointers and count define what is valid.
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W:0]   count_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic   push;
    logic   pop;
    logic   flush_hit;
    entry_t head;

    // Accept/hold and valid depend on registered state only, so neither
    // flush_i nor id_ready_i has a combinational path to the PC.
    assign PCWrite_o  = (count_q < FULL_CNT);
    assign id_valid_o = (count_q != '0);

    assign push = fetch_valid_i & PCWrite_o  & ~flush_i;
    assign pop  = id_valid_o    & id_ready_i & ~flush_i;

    // A flush only counts when it actually threw something away: a buffered
    // entry or the word being fetched this cycle.
    assign flush_hit = flush_i & ((count_q != '0) | fetch_valid_i);

    // First-word fall-through from the registered head slot.
    assign head          = mem_q[rptr_q];
    assign id_pc_o       = id_valid_o ? head.pc    : 32'h0;
    assign id_instr_o    = id_valid_o ? head.instr : 32'h0;
    assign id_pc_plus4_o = id_pc_o + 32'd4;

    assign count_o     = count_q;
    assign flush_cnt_o = flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= '{pc: pc_i, instr: instr_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            if (flush_hit && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on overflow.
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [31:0]      pc_i;
    logic [31:0]      instr_i;
    logic             fetch_valid_i;
    logic             PCWrite_o;
    logic             flush_i;
    logic             id_ready_i;
    logic             id_valid_o;
    logic [31:0]      id_pc_o;
    logic [31:0]      id_pc_plus4_o;
    logic [31:0]      id_instr_o;
    logic [CW-1:0]    count_o;
    logic [CNT_W-1:0] flush_cnt_o;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .instr_i       (instr_i),
        .fetch_valid_i (fetch_valid_i),
        .PCWrite_o     (PCWrite_o),
        .flush_i       (flush_i),
        .id_ready_i    (id_ready_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o),
        .id_instr_o    (id_instr_o),
        .count_o       (count_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    // Inputs applied during a cycle, and the outputs expected in that same
    // cycle (i.e. the state left by the previous edges).
    typedef struct {
        logic             rst;
        logic             fv;
        logic [31:0]      pc;
        logic             fl;
        logic             rdy;
        logic             e_v;
        logic [31:0]      e_pc;
        logic [31:0]      e_p4;
        logic [CW-1:0]    e_cnt;
        logic             e_pcw;
        logic [CNT_W-1:0] e_fc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Instruction word tied to its address so ordering errors show in instr too.
    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic void add(input logic rst, input logic fv, input logic [31:0] pc,
                                input logic fl, input logic rdy, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ep4,
                                input int ecnt, input logic epcw, input int efc);
        vec_t v;
        v.rst = rst; v.fv = fv; v.pc = pc; v.fl = fl; v.rdy = rdy;
        v.e_v = ev; v.e_pc = epc; v.e_p4 = ep4; v.e_cnt = CW'(ecnt);
        v.e_pcw = epcw; v.e_fc = CNT_W'(efc);
        vecs.push_back(v);
    endfunction

    function automatic void add_empty(input logic rst, input logic fv, input logic [31:0] pc,
                                      input logic fl, input logic rdy, input int efc);
        add(rst, fv, pc, fl, rdy, 1'b0, 32'h0, 32'h4, 0, 1'b1, efc);
    endfunction

    task automatic drive(input logic rst, input logic fv, input logic [31:0] pc,
                         input logic fl, input logic rdy);
        rst_i = rst; fetch_valid_i = fv; pc_i = pc; instr_i = ins(pc);
        flush_i = fl; id_ready_i = rdy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input vec_t v);
        logic [31:0] e_ins;
        e_ins = v.e_v ? ins(v.e_pc) : 32'h0;
        n_vec++;
        if (id_valid_o !== v.e_v || id_pc_o !== v.e_pc || id_pc_plus4_o !== v.e_p4 ||
            id_instr_o !== e_ins || count_o !== v.e_cnt || PCWrite_o !== v.e_pcw ||
            flush_cnt_o !== v.e_fc) begin
            n_bad++;
            $display("FAIL %s: got v=%b pc=%h p4=%h ins=%h cnt=%0d pcw=%b fc=%0d; want v=%b pc=%h p4=%h ins=%h cnt=%0d pcw=%b fc=%0d",
                     name, id_valid_o, id_pc_o, id_pc_plus4_o, id_instr_o, count_o, PCWrite_o,
                     flush_cnt_o, v.e_v, v.e_pc, v.e_p4, e_ins, v.e_cnt, v.e_pcw, v.e_fc);
        end
    endtask

    task automatic check_bit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        // reset then stream 0x0, 0x4, 0x8
        add_empty(1, 0, 32'h0,  0, 0, 0);
        add_empty(1, 1, 32'h0,  0, 1, 0);
        add      (1, 1, 32'h4,  0, 1, 1, 32'h0, 32'h4, 1, 1, 0);
        add      (1, 1, 32'h8,  0, 1, 1, 32'h4, 32'h8, 1, 1, 0);
        add      (1, 0, 32'h0,  0, 1, 1, 32'h8, 32'hC, 1, 1, 0);
        add_empty(1, 0, 32'h0,  0, 0, 0);
        // fill, refused fetch of 0x18, refetch after drain starts
        add_empty(1, 1, 32'h10, 0, 0, 0);
        add      (1, 1, 32'h14, 0, 0, 1, 32'h10, 32'h14, 1, 1, 0);
        add      (1, 1, 32'h18, 0, 0, 1, 32'h10, 32'h14, 2, 0, 0);
        add      (1, 1, 32'h18, 0, 1, 1, 32'h10, 32'h14, 2, 0, 0);
        add      (1, 1, 32'h18, 0, 1, 1, 32'h14, 32'h18, 1, 1, 0);
        add      (1, 0, 32'h0,  0, 1, 1, 32'h18, 32'h1C, 1, 1, 0);
        add_empty(1, 0, 32'h0,  0, 0, 0);
        // flush with 2 buffered plus an in-flight fetch
        add_empty(1, 1, 32'h20, 0, 0, 0);
        add      (1, 1, 32'h24, 0, 0, 1, 32'h20, 32'h24, 1, 1, 0);
        add      (1, 1, 32'h28, 1, 0, 1, 32'h20, 32'h24, 2, 0, 0);
        add_empty(1, 0, 32'h0,  0, 0, 1);
        // flush of nothing: counter unchanged
        add_empty(1, 0, 32'h0,  1, 0, 1);
        add_empty(1, 0, 32'h0,  0, 0, 1);
        // flush of an empty queue with an in-flight fetch: counts
        add_empty(1, 1, 32'h2C, 1, 0, 1);
        add_empty(1, 0, 32'h0,  0, 0, 2);
        // simultaneous push/pop at count 1 for 10 cycles
        add_empty(1, 1, 32'h100, 0, 1, 2);
        for (int i = 1; i <= 10; i++)
            add(1, 1, 32'h100 + 32'(4*i), 0, 1, 1, 32'h100 + 32'(4*(i-1)),
                32'h100 + 32'(4*i), 1, 1, 2);
        add      (1, 0, 32'h0,  0, 1, 1, 32'h128, 32'h12C, 1, 1, 2);
        add_empty(1, 0, 32'h0,  0, 0, 2);
        // reset while full and flushing
        add_empty(1, 1, 32'h200, 0, 0, 2);
        add      (1, 1, 32'h204, 0, 0, 1, 32'h200, 32'h204, 1, 1, 2);
        add      (0, 1, 32'h208, 1, 0, 1, 32'h200, 32'h204, 2, 0, 2);
        add_empty(1, 0, 32'h0,  0, 0, 0);
        // pc + 4 wraps
        add_empty(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
        add      (1, 0, 32'h0,  0, 1, 1, 32'hFFFF_FFFC, 32'h0, 1, 1, 0);
        add_empty(1, 0, 32'h0,  0, 0, 0);

        drive(0, 0, 32'h0, 0, 0);
        step();
        step();

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].fv, vecs[k].pc, vecs[k].fl, vecs[k].rdy);
            #1;
            check_vec($sformatf("vec%0d", k), vecs[k]);
            step();
        end

        // Fill until PCWrite_o drops, within a bounded number of cycles.
        begin
            logic [31:0] pc;
            int          cyc;
            pc  = 32'h300;
            cyc = 0;
            drive(1, 1, pc, 0, 0);
            #1;
            while (PCWrite_o === 1'b1 && cyc < 10) begin
                step();
                pc  = pc + 32'h4;
                cyc = cyc + 1;
                drive(1, 1, pc, 0, 0);
                #1;
            end
            check_bit("fill_pcwrite_low", {31'h0, PCWrite_o}, 32'h0);
            check_bit("fill_count", 32'(count_o), 32'(DEPTH));
            check_bit("fill_pc_held", pc, 32'h300 + 32'(4*DEPTH));
            // offered fetch while full must not be stored
            repeat (3) step();
            check_bit("hold_count", 32'(count_o), 32'(DEPTH));
            // drain in order
            drive(1, 0, 32'h0, 0, 1);
            for (int i = 0; i < DEPTH; i++) begin
                #1;
                check_bit($sformatf("drain%0d_pc", i), id_pc_o, 32'h300 + 32'(4*i));
                check_bit($sformatf("drain%0d_ins", i), id_instr_o, ins(32'h300 + 32'(4*i)));
                step();
            end
            check_bit("drain_empty", {31'h0, id_valid_o}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the program counter / instruction memory and the decode stage of the pipelined CPU. It consumes the current fetch address and the fetched instruction word each cycle, buffers up to DEPTH entries, and presents them in order to decode. It is the other end of the PC's `PCWrite` interface: it generates the PC advance/hold signal from its own occupancy, and it discards buffered instructions on a pipeline flush.

## Interface
- DEPTH, 2: queue entries; power of two, at least 2.
- CNT_W, 16: width of the flush statistics counter.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- pc_i  in  32  address of the instruction currently presented on instr_i.
- instr_i  in  32  instruction word read from instruction memory at pc_i.
- fetch_valid_i  in  1  pc_i and instr_i are valid this cycle.
- PCWrite_o  out  1  1 means the queue accepts this fetch and the PC advances; 0 means the PC must hold and refetch.
- flush_i  in  1  branch or jump resolved taken; discard all buffered and in-flight instructions.
- id_ready_i  in  1  decode consumes the head entry this cycle.
- id_valid_o  out  1  head entry is valid.
- id_pc_o  out  32  address of the head instruction.
- id_pc_plus4_o  out  32  id_pc_o + 4, computed modulo 2^32.
- id_instr_o  out  32  head instruction word; 32'h0 (nop) when id_valid_o = 0.
- count_o  out  log2(DEPTH)+1  current occupancy.
- flush_cnt_o  out  CNT_W  number of flushes that discarded at least one valid entry or in-flight fetch; saturates at all-ones.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {pc, instr}. Read and write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is held in a separate counter.
- PCWrite_o = (count < DEPTH). It depends only on registered state; there is no combinational path from id_ready_i or flush_i.
- push = fetch_valid_i & PCWrite_o & ~flush_i.
- pop = id_valid_o & id_ready_i & ~flush_i.
- id_valid_o = (count != 0). The id_* outputs show the head entry, first-word fall-through from registered storage. When the queue is empty, id_pc_o = 0, id_pc_plus4_o = 4, and id_instr_o = 0.
- Push only: write the entry at wptr, increment wptr and count.
- Pop only: increment rptr, decrement count.
- Push and pop together: both pointers advance and count is unchanged. This is legal at any occupancy below DEPTH. When full, no push occurs, because PCWrite_o = 0.
- flush_i = 1 takes priority over everything. Next cycle rptr = wptr = 0 and count = 0, and no push or pop takes effect that cycle. flush_cnt_o increments if count != 0 or fetch_valid_i = 1 in the flush cycle.
- Instructions are never reordered, duplicated, or dropped except by flush.

## Timing
- Reset (rst_i = 0 at a clock edge): count = 0, pointers = 0, flush_cnt_o = 0, id_valid_o = 0, PCWrite_o = 1, and id_* take their empty values. Storage contents are don't-care. Reset overrides flush, push, and pop in the same cycle.
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle).
- Full: PCWrite_o drops in the cycle after the DEPTH-th push. It rises in the cycle after the first pop or flush. The fetch offered while PCWrite_o = 0 is not stored; the PC repeats that same address.
- Empty with push in the same cycle: id_valid_o stays 0 in that cycle, because there is no bypass.
- Flush in the same cycle as fetch_valid_i: the fetched word is discarded and PCWrite_o stays 1.
- Pointer wrap: after DEPTH pushes and DEPTH pops, the pointers return to 0 with no gap and no duplication.

## Test plan
- Reset then stream: push pc = 0x0, 0x4, 0x8 with id_ready_i = 1 throughout. Required: id_pc_o shows 0x0, 0x4, 0x8 on consecutive cycles, each one cycle after its push. id_pc_plus4_o shows 0x4, 0x8, 0xC. PCWrite_o stays 1.
- Fill (DEPTH = 2, id_ready_i = 0): push 0x10 and 0x14. Required: count_o = 2 and PCWrite_o = 0. Offer 0x18, then raise id_ready_i; the bench refetches 0x18 after PCWrite_o returns to 1. Required: pop order 0x10, 0x14, 0x18, and count never exceeds 2.
- Flush: with 2 entries buffered and fetch_valid_i = 1, assert flush_i for one cycle. Required next cycle: count_o = 0, id_valid_o = 0, id_instr_o = 0, PCWrite_o = 1, and flush_cnt_o = 1. A flush with an empty queue and fetch_valid_i = 0 leaves flush_cnt_o unchanged.
- Simultaneous push and pop at count = 1 for 10 cycles. Required: count_o stays 1, pops occur in address order, and the pointers wrap without loss.
- Reset mid-operation: assert rst_i = 0 while full and while flush_i = 1. Required next cycle: all reset values, and flush_cnt_o = 0.
- Wrap at address 0xFFFFFFFC. Required: id_pc_plus4_o = 0x00000000.
